ber_sequencer: RTL and testbench
================================

BER_SEQUENCER -- requirements
Module: ber_sequencer

Interface
REQ-001 SHALL have parameter GPIO_LEN, default 32, command/response word width.
REQ-002 SHALL have parameter WIN_LEN, default 32, measurement-window counter width.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  one-cycle request to run a measurement.
REQ-006 SHALL have port abort  in  1  cancel a running measurement.
REQ-007 SHALL have port phase  in  2  phase value to program, sampled at start.
REQ-008 SHALL have port window_len  in  WIN_LEN  run duration in cycles, sampled at start.
REQ-009 SHALL have port gpio_cmd  out  GPIO_LEN  register-file command word {opcode[31:24], enable[23], data[22:0]}.
REQ-010 SHALL have port gpio_rsp  in  GPIO_LEN  register-file read-back word.
REQ-011 SHALL have port rd_data  out  GPIO_LEN  captured count word.
REQ-012 SHALL have port rd_idx  out  3  index of rd_data (0..7).
REQ-013 SHALL have port rd_valid  out  1  rd_data valid.
REQ-014 SHALL have port rd_ready  in  1  consumer accepts rd_data.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port done  out  1  one-cycle pulse when the eighth word is accepted.

Function
REQ-017 SHALL implement states IDLE, RST_ON, RST_OFF, SET_PH, EN, RUN, LATCH, DIS, RD_CMD, RD_WAIT, RD_CAP, OUT, ABORT, DONE.
REQ-018 IDLE: gpio_cmd = 0 (enable bit 0); start -> RST_ON, latching phase and window_len; start while busy SHALL be ignored.
REQ-019 Each command state SHALL last exactly one cycle with enable bit 1; all other states drive gpio_cmd = 0.
REQ-020 RST_ON issues opcode 0x00 data 1; RST_OFF opcode 0x00 data 0; SET_PH opcode 0x02 data = phase; EN opcode 0x01 data = 3'b111.
REQ-021 RUN SHALL last max(window_len,1) cycles, counted by an internal down-counter; window_len = 0 SHALL behave as 1.
REQ-022 LATCH issues opcode 0x88; DIS issues opcode 0x01 data 0.
REQ-023 Read loop for idx 0..7: RD_CMD issues opcode 0x80+idx; RD_WAIT one idle cycle; RD_CAP registers gpio_rsp into rd_data; OUT holds rd_valid.
REQ-024 Read order SHALL be bit_re hi, bit_re lo, bit_im hi, bit_im lo, err_re hi, err_re lo, err_im hi, err_im lo.
REQ-025 OUT: rd_data/rd_idx SHALL stay stable while rd_valid & !rd_ready; a transfer occurs when rd_valid & rd_ready.
REQ-026 After a transfer, idx < 7 -> RD_CMD with idx+1; idx = 7 -> DONE.
REQ-027 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-028 abort in any state other than IDLE, ABORT or DONE -> ABORT; ABORT issues opcode 0x01 data 0, then IDLE; done SHALL NOT pulse.
REQ-029 abort and start together in IDLE: abort SHALL win and start SHALL be dropped.
REQ-030 abort on the same cycle as an OUT transfer SHALL take precedence and drop the transfer.

Reset
REQ-031 rst SHALL force IDLE, gpio_cmd = 0, rd_data = 0, rd_idx = 0, rd_valid = 0, busy = 0, done = 0, and clear the counters from any state, including mid-RUN or mid-OUT.

Structure
REQ-032 Opcode constants (0x00, 0x01, 0x02, 0x80..0x88), field positions and the state encoding SHALL live in a shared package ber_ctrl_pkg, also used by the register file.
REQ-033 The RUN down-counter SHALL be the sub-module ber_window_timer (load, tick, expire).

Verification
REQ-034 start, phase 2, window_len 5, with a register-file model attached -> gpio_cmd sequence 0x00800001, 0x00800000, 0x02800002, 0x01800007, then 5 RUN cycles, then 0x88800000, 0x01800000.
REQ-035 Model counts 0x0000000A_00000010 per register, rd_ready held 1 -> 8 words in idx order 0..7 with hi/lo correct; done pulses exactly once.
REQ-036 rd_ready held 0 for 10 cycles at idx 3 -> rd_data/rd_idx held stable for all 10 cycles; read then resumes at idx 4.
REQ-037 abort at the third RUN cycle -> next cycle 0x01800000, then IDLE; no rd_valid, no done.
REQ-038 window_len 0 -> RUN lasts exactly 1 cycle; start while busy -> no effect.
REQ-039 rst asserted in OUT -> all outputs at reset values on the next cycle; a new start then runs a full sequence.

Source files
------------

// File: rtl/ber_ctrl_pkg.sv
// Shared definitions for the BER measurement controller and its register
// file: command word layout, opcodes and the sequencer state encoding.
package ber_ctrl_pkg;

   // Command word layout: {opcode[31:24], enable[23], data[22:0]}
   localparam int CMD_W  = 32;
   localparam int OP_MSB = 31;
   localparam int OP_LSB = 24;
   localparam int EN_BIT = 23;
   localparam int DATA_W = 23;

   // Register-file opcodes
   localparam logic [7:0] OP_RST     = 8'h00;  // data 1 = hold counters in reset
   localparam logic [7:0] OP_EN      = 8'h01;  // data = per-lane enable mask
   localparam logic [7:0] OP_PHASE   = 8'h02;  // data = sampling phase
   localparam logic [7:0] OP_RD_BASE = 8'h80;  // 0x80..0x87 select read-back word
   localparam logic [7:0] OP_LATCH   = 8'h88;  // snapshot all counters

   localparam logic [DATA_W-1:0] DATA_EN_ALL = 23'h7;

   // Read-back words, in order: bit_re hi/lo, bit_im hi/lo, err_re hi/lo, err_im hi/lo
   localparam int NUM_WORDS = 8;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_RST_ON  = 4'd1,
      S_RST_OFF = 4'd2,
      S_SET_PH  = 4'd3,
      S_EN      = 4'd4,
      S_RUN     = 4'd5,
      S_LATCH   = 4'd6,
      S_DIS     = 4'd7,
      S_RD_CMD  = 4'd8,
      S_RD_WAIT = 4'd9,
      S_RD_CAP  = 4'd10,
      S_OUT     = 4'd11,
      S_ABORT   = 4'd12,
      S_DONE    = 4'd13
   } ber_state_e;

   // Build an enabled command word
   function automatic logic [CMD_W-1:0] make_cmd(input logic [7:0] op,
                                                 input logic [DATA_W-1:0] data);
      logic [CMD_W-1:0] w;
      w                 = '0;
      w[OP_MSB:OP_LSB]  = op;
      w[EN_BIT]         = 1'b1;
      w[DATA_W-1:0]     = data;
      return w;
   endfunction

endpackage

// File: rtl/ber_window_timer.sv
// Measurement-window down-counter. A load of 0 is treated as 1 so the
// window always lasts at least one cycle; expire is high on the last cycle.
module ber_window_timer #(
   parameter int WIN_LEN = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [WIN_LEN-1:0] len,
   input  logic               tick,
   output logic               expire
);

   localparam logic [WIN_LEN-1:0] ONE = WIN_LEN'(1);

   logic [WIN_LEN-1:0] cnt;

   // Load the window length, then count down once per tick until empty
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= (len == '0) ? ONE : len;
      end else if (tick && (cnt != '0)) begin
         cnt <= cnt - ONE;
      end
   end

   assign expire = (cnt == ONE);

endmodule

// File: rtl/ber_sequencer.sv
// BER measurement sequencer: programs the register file through gpio_cmd,
// runs a timed window, latches the counters and streams the eight count
// words out on rd_data/rd_idx.
//
// Output handshake: rd_valid rises with rd_data/rd_idx already valid; the
// three stay unchanged while rd_valid && !rd_ready; a word is transferred on
// a rising clk edge where rd_valid && rd_ready (unless abort is also high,
// in which case the word is dropped); rd_valid falls on the cycle after.
module ber_sequencer
   import ber_ctrl_pkg::*;
#(
   parameter int GPIO_LEN = 32,
   parameter int WIN_LEN  = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [1:0]          phase,
   input  logic [WIN_LEN-1:0]  window_len,
   output logic [GPIO_LEN-1:0] gpio_cmd,
   input  logic [GPIO_LEN-1:0] gpio_rsp,
   output logic [GPIO_LEN-1:0] rd_data,
   output logic [2:0]          rd_idx,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic                busy,
   output logic                done,
   output ber_state_e          state_dbg
);

   localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

   ber_state_e state;
   logic [1:0] phase_q;
   logic [2:0] idx;
   logic       abort_hit;
   logic       timer_load;
   logic       run_tick;
   logic       run_expire;

   // abort is honoured everywhere except where the sequence is already ending
   assign abort_hit  = abort && !(state inside {S_IDLE, S_ABORT, S_DONE});
   assign timer_load = (state == S_IDLE) && start && !abort;
   assign run_tick   = (state == S_RUN);
   assign state_dbg  = state;

   ber_window_timer #(.WIN_LEN(WIN_LEN)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (timer_load),
      .len    (window_len),
      .tick   (run_tick),
      .expire (run_expire)
   );

   // Sequencer FSM; each command is registered on entry to its state so it
   // is on gpio_cmd for exactly that state's single cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         gpio_cmd <= '0;
         rd_data  <= '0;
         rd_idx   <= '0;
         rd_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         phase_q  <= '0;
         idx      <= '0;
      end else begin
         gpio_cmd <= '0;
         done     <= 1'b0;
         if (abort_hit) begin
            state    <= S_ABORT;
            gpio_cmd <= GPIO_LEN'(make_cmd(OP_EN, 23'd0));
            rd_valid <= 1'b0;
            busy     <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !abort) begin
                     state    <= S_RST_ON;
                     phase_q  <= phase;
                     idx      <= '0;
                     busy     <= 1'b1;
                     gpio_cmd <= GPIO_LEN'(make_cmd(OP_RST, 23'd1));
                  end
               end
               S_RST_ON: begin
                  state    <= S_RST_OFF;
                  gpio_cmd <= GPIO_LEN'(make_cmd(OP_RST, 23'd0));
               end
               S_RST_OFF: begin
                  state    <= S_SET_PH;
                  gpio_cmd <= GPIO_LEN'(make_cmd(OP_PHASE, {21'd0, phase_q}));
               end
               S_SET_PH: begin
                  state    <= S_EN;
                  gpio_cmd <= GPIO_LEN'(make_cmd(OP_EN, DATA_EN_ALL));
               end
               S_EN: begin
                  state <= S_RUN;
               end
               S_RUN: begin
                  if (run_expire) begin
                     state    <= S_LATCH;
                     gpio_cmd <= GPIO_LEN'(make_cmd(OP_LATCH, 23'd0));
                  end
               end
               S_LATCH: begin
                  state    <= S_DIS;
                  gpio_cmd <= GPIO_LEN'(make_cmd(OP_EN, 23'd0));
               end
               S_DIS: begin
                  state    <= S_RD_CMD;
                  gpio_cmd <= GPIO_LEN'(make_cmd(OP_RD_BASE | {5'd0, idx}, 23'd0));
               end
               S_RD_CMD: begin
                  state <= S_RD_WAIT;
               end
               S_RD_WAIT: begin
                  state <= S_RD_CAP;
               end
               S_RD_CAP: begin
                  state    <= S_OUT;
                  rd_data  <= gpio_rsp;
                  rd_idx   <= idx;
                  rd_valid <= 1'b1;
               end
               S_OUT: begin
                  if (rd_ready) begin
                     rd_valid <= 1'b0;
                     if (idx == LAST_IDX) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else begin
                        state    <= S_RD_CMD;
                        idx      <= idx + 3'd1;
                        gpio_cmd <= GPIO_LEN'(make_cmd(OP_RD_BASE | {5'd0, idx + 3'd1}, 23'd0));
                     end
                  end
               end
               S_DONE: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               S_ABORT: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ber_sequencer.sv
// Directed bench for ber_sequencer with a small register-file model.
module tb_ber_sequencer;
   import ber_ctrl_pkg::*;

   localparam logic [31:0] C_RST_ON  = 32'h0080_0001;
   localparam logic [31:0] C_RST_OFF = 32'h0080_0000;
   localparam logic [31:0] C_EN_ALL  = 32'h0180_0007;
   localparam logic [31:0] C_LATCH   = 32'h8880_0000;
   localparam logic [31:0] C_DIS     = 32'h0180_0000;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [1:0]  phase = '0;
   logic [31:0] window_len = '0;
   logic [31:0] gpio_cmd;
   logic [31:0] gpio_rsp;
   logic [31:0] rd_data;
   logic [2:0]  rd_idx;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic        busy;
   logic        done;
   ber_state_e  state_dbg;

   always #5 clk = ~clk;

   ber_sequencer #(.GPIO_LEN(32), .WIN_LEN(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .phase      (phase),
      .window_len (window_len),
      .gpio_cmd   (gpio_cmd),
      .gpio_rsp   (gpio_rsp),
      .rd_data    (rd_data),
      .rd_idx     (rd_idx),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .busy       (busy),
      .done       (done),
      .state_dbg  (state_dbg)
   );

   // ---------------- register-file model ----------------
   logic [63:0] cnt_val [4];   // bit_re, bit_im, err_re, err_im
   logic [63:0] snap    [4];

   function automatic logic [31:0] sel_word(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] c, input logic [63:0] d,
                                            input int i);
      logic [63:0] v;
      case (i / 2)
         0:       v = a;
         1:       v = b;
         2:       v = c;
         default: v = d;
      endcase
      return (i % 2 == 0) ? v[63:32] : v[31:0];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         gpio_rsp <= '0;
      end else if (gpio_cmd[23]) begin
         if (gpio_cmd[31:24] == 8'h88) begin
            for (int k = 0; k < 4; k++) snap[k] <= cnt_val[k];
         end else if (gpio_cmd[31:27] == 5'b10000) begin
            gpio_rsp <= sel_word(snap[0], snap[1], snap[2], snap[3], int'(gpio_cmd[26:24]));
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [31:0] exp_cmd_q[$];
   logic [34:0] exp_rd_q[$];
   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int valid_cnt = 0;
   int run_cnt = 0;
   int last_run = -1;
   bit in_run = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input int i);
      return sel_word(cnt_val[0], cnt_val[1], cnt_val[2], cnt_val[3], i);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_setup(input logic [1:0] ph);
      exp_cmd_q.push_back(C_RST_ON);
      exp_cmd_q.push_back(C_RST_OFF);
      exp_cmd_q.push_back(32'h0280_0000 | {30'd0, ph});
      exp_cmd_q.push_back(C_EN_ALL);
   endtask

   task automatic push_full(input logic [1:0] ph);
      push_setup(ph);
      exp_cmd_q.push_back(C_LATCH);
      exp_cmd_q.push_back(C_DIS);
      for (int i = 0; i < 8; i++) begin
         logic [2:0] ii;
         ii = 3'(i);
         exp_cmd_q.push_back({5'b10000, ii, 1'b1, 23'd0});
         exp_rd_q.push_back({ii, exp_word(i)});
      end
   endtask

   task automatic pulse_start(input logic [1:0] ph, input logic [31:0] wl);
      phase = ph;
      window_len = wl;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n;
      n = 0;
      while (!rd_valid && n < budget) begin
         tick();
         n++;
      end
      if (!rd_valid) check({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic clear_stats();
      done_cnt = 0;
      valid_cnt = 0;
      last_run = -1;
      in_run = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      fork
         forever begin
            @(negedge clk);
            if (!rst) begin
               if (gpio_cmd != '0) begin
                  if (gpio_cmd == C_EN_ALL) begin
                     in_run = 1'b1;
                     run_cnt = 0;
                  end else if (gpio_cmd == C_LATCH && in_run) begin
                     in_run = 1'b0;
                     last_run = run_cnt;
                  end else if (gpio_cmd == C_DIS) begin
                     in_run = 1'b0;
                  end
                  if (exp_cmd_q.size() == 0) check("cmd_extra", 64'(gpio_cmd), 64'd0);
                  else check("cmd", 64'(gpio_cmd), 64'(exp_cmd_q.pop_front()));
               end else if (in_run) begin
                  run_cnt++;
               end
               if (rd_valid && rd_ready && !abort) begin
                  if (exp_rd_q.size() == 0) check("rd_extra", 64'({rd_idx, rd_data}), 64'd0);
                  else check("rd_word", 64'({rd_idx, rd_data}), 64'(exp_rd_q.pop_front()));
               end
               if (rd_valid) valid_cnt++;
               if (done) done_cnt++;
            end
         end
      join_none

      // Reset state
      for (int k = 0; k < 4; k++) cnt_val[k] = 64'h0000000A_00000010;
      repeat (3) tick();
      check("rst_gpio_cmd", 64'(gpio_cmd), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_state", 64'(state_dbg), 64'(S_IDLE));
      rst = 1'b0;
      tick();

      // Full run: phase 2, window 5, consumer always ready
      clear_stats();
      rd_ready = 1'b1;
      push_full(2'd2);
      pulse_start(2'd2, 32'd5);
      check("a_busy", 64'(busy), 64'd1);
      wait_done("a_done", 300);
      repeat (2) tick();
      check("a_run_len", 64'(last_run), 64'd5);
      check("a_done_cnt", 64'(done_cnt), 64'd1);
      check("a_busy_end", 64'(busy), 64'd0);
      check("a_cmd_q", 64'(exp_cmd_q.size()), 64'd0);
      check("a_rd_q", 64'(exp_rd_q.size()), 64'd0);

      // Distinct counters, consumer paced by the bench, stall at idx 3
      clear_stats();
      cnt_val[0] = 64'h00000001_00000002;
      cnt_val[1] = 64'h00000003_00000004;
      cnt_val[2] = 64'h00000005_00000006;
      cnt_val[3] = 64'h00000007_00000008;
      rd_ready = 1'b0;
      push_full(2'd1);
      pulse_start(2'd1, 32'd3);
      for (int w = 0; w < 8; w++) begin
         wait_valid("b_valid", 60);
         check("b_idx", 64'(rd_idx), 64'(w));
         if (w == 3) begin
            for (int k = 0; k < 10; k++) begin
               check("b_hold_valid", 64'(rd_valid), 64'd1);
               check("b_hold_idx", 64'(rd_idx), 64'd3);
               check("b_hold_data", 64'(rd_data), 64'(exp_word(3)));
               tick();
            end
         end
         rd_ready = 1'b1;
         tick();
         rd_ready = 1'b0;
      end
      wait_done("b_done", 20);
      repeat (2) tick();
      check("b_run_len", 64'(last_run), 64'd3);
      check("b_done_cnt", 64'(done_cnt), 64'd1);
      check("b_rd_q", 64'(exp_rd_q.size()), 64'd0);

      // Abort on the third RUN cycle
      clear_stats();
      rd_ready = 1'b1;
      push_setup(2'd0);
      pulse_start(2'd0, 32'd8);
      begin
         int n;
         n = 0;
         while (gpio_cmd != C_EN_ALL && n < 20) begin
            tick();
            n++;
         end
         if (gpio_cmd != C_EN_ALL) check("c_en_timeout", 64'd0, 64'd1);
      end
      tick();  // RUN cycle 1
      tick();  // RUN cycle 2
      tick();  // RUN cycle 3
      exp_cmd_q.push_back(C_DIS);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("c_abort_cmd", 64'(gpio_cmd), 64'(C_DIS));
      check("c_abort_busy", 64'(busy), 64'd1);
      tick();
      check("c_idle_busy", 64'(busy), 64'd0);
      check("c_idle_state", 64'(state_dbg), 64'(S_IDLE));
      repeat (20) tick();
      check("c_no_valid", 64'(valid_cnt), 64'd0);
      check("c_no_done", 64'(done_cnt), 64'd0);
      check("c_cmd_q", 64'(exp_cmd_q.size()), 64'd0);

      // abort and start together in IDLE: nothing starts
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      tick();
      check("d_abort_start_busy", 64'(busy), 64'd0);
      check("d_abort_start_cmd", 64'(gpio_cmd), 64'd0);

      // window_len 0 runs one cycle; start while busy is ignored
      clear_stats();
      for (int k = 0; k < 4; k++) cnt_val[k] = {32'($urandom), 32'($urandom)};
      push_full(2'd0);
      pulse_start(2'd0, 32'd0);
      repeat (3) tick();
      pulse_start(2'd3, 32'd9);
      repeat (10) tick();
      pulse_start(2'd1, 32'd4);
      wait_done("d_done", 300);
      repeat (10) tick();
      check("d_run_len", 64'(last_run), 64'd1);
      check("d_done_cnt", 64'(done_cnt), 64'd1);
      check("d_busy_end", 64'(busy), 64'd0);
      check("d_cmd_q", 64'(exp_cmd_q.size()), 64'd0);

      // abort coincident with an OUT transfer drops the word
      clear_stats();
      rd_ready = 1'b0;
      push_setup(2'd3);
      exp_cmd_q.push_back(C_LATCH);
      exp_cmd_q.push_back(C_DIS);
      exp_cmd_q.push_back(32'h8080_0000);
      pulse_start(2'd3, 32'd2);
      wait_valid("f_valid", 60);
      exp_cmd_q.push_back(C_DIS);
      rd_ready = 1'b1;
      abort = 1'b1;
      tick();
      rd_ready = 1'b0;
      abort = 1'b0;
      check("f_abort_cmd", 64'(gpio_cmd), 64'(C_DIS));
      check("f_valid_drop", 64'(rd_valid), 64'd0);
      tick();
      check("f_busy", 64'(busy), 64'd0);
      check("f_no_done", 64'(done_cnt), 64'd0);
      check("f_cmd_q", 64'(exp_cmd_q.size()), 64'd0);

      // rst while in OUT, then a fresh full run
      clear_stats();
      for (int k = 0; k < 4; k++) cnt_val[k] = 64'h0000000A_00000010;
      push_full(2'd2);
      pulse_start(2'd2, 32'd4);
      wait_valid("e_valid", 60);
      rst = 1'b1;
      tick();
      check("e_gpio_cmd", 64'(gpio_cmd), 64'd0);
      check("e_rd_data", 64'(rd_data), 64'd0);
      check("e_rd_idx", 64'(rd_idx), 64'd0);
      check("e_rd_valid", 64'(rd_valid), 64'd0);
      check("e_busy", 64'(busy), 64'd0);
      check("e_done", 64'(done), 64'd0);
      check("e_state", 64'(state_dbg), 64'(S_IDLE));
      rst = 1'b0;
      exp_cmd_q.delete();
      exp_rd_q.delete();
      tick();
      clear_stats();
      rd_ready = 1'b1;
      cnt_val[0] = 64'h11111111_22222222;
      push_full(2'd3);
      pulse_start(2'd3, 32'd2);
      wait_done("e2_done", 300);
      repeat (2) tick();
      check("e2_run_len", 64'(last_run), 64'd2);
      check("e2_done_cnt", 64'(done_cnt), 64'd1);
      check("e2_cmd_q", 64'(exp_cmd_q.size()), 64'd0);
      check("e2_rd_q", 64'(exp_rd_q.size()), 64'd0);

      // Final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
